// File: rtl/srlor_bank.sv
// -----------------------------------------------------------------------------
// srlor_bank
//
// Purpose:
//   A bank of CHANNELS independent flags written from asynchronous event
//   sources. Each flag takes the value of its s bit whenever its en bit is
//   asserted. The block also offers a global synchronous clear, an OR-reduced
//   "any" flag, and a 4-phase read handshake that snapshots the flags and can
//   optionally clear the flags it captured.
//
// Ports:
//   clk      in   1         system clock, rising edge
//   rst_n    in   1         asynchronous active-low reset
//   en       in   CHANNELS  per-channel enable, asynchronous to clk
//   s        in   CHANNELS  per-channel data (1 = set, 0 = clear) when en=1
//   clr      in   1         synchronous global clear, active high
//   q        out  CHANNELS  registered flag state
//   any      out  1         OR of q
//   rd_req   in   1         read request (4-phase)
//   rd_ack   out  1         read acknowledge, registered
//   rd_data  out  CHANNELS  snapshot of q, valid while rd_ack=1
//
// Read handshake (4-phase): the requester raises rd_req and waits for rd_ack.
// The edge on which rd_ack rises is the capture edge: rd_data takes the value
// q had just before that edge. rd_data is held stable while rd_ack=1. The
// requester drops rd_req, the block drops rd_ack, and rd_data keeps its last
// value. A new capture needs rd_req to have been seen low since the previous
// capture, so a requester that leaves rd_req high gets exactly one snapshot.
// -----------------------------------------------------------------------------
module srlor_bank #(
  parameter int CHANNELS      = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int CLEAR_ON_READ = 1,
  parameter int SET_PRIORITY  = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] en,
  input  logic [CHANNELS-1:0] s,
  input  logic                clr,
  output logic [CHANNELS-1:0] q,
  output logic                any,
  input  logic                rd_req,
  output logic                rd_ack,
  output logic [CHANNELS-1:0] rd_data
);

  // Synchronised copies of en and s. Both buses go through identical chains,
  // so an en bit and its s bit stay aligned cycle for cycle.
  logic [CHANNELS-1:0] en_y;
  logic [CHANNELS-1:0] s_y;

  generate
    if (SYNC_STAGES == 0) begin : g_bypass
      assign en_y = en;
      assign s_y  = s;
    end else begin : g_sync
      logic [CHANNELS-1:0] en_sr [SYNC_STAGES];
      logic [CHANNELS-1:0] s_sr  [SYNC_STAGES];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < SYNC_STAGES; k++) begin
            en_sr[k] <= '0;
            s_sr[k]  <= '0;
          end
        end else begin
          en_sr[0] <= en;
          s_sr[0]  <= s;
          for (int k = 1; k < SYNC_STAGES; k++) begin
            en_sr[k] <= en_sr[k-1];
            s_sr[k]  <= s_sr[k-1];
          end
        end
      end

      assign en_y = en_sr[SYNC_STAGES-1];
      assign s_y  = s_sr[SYNC_STAGES-1];
    end
  endgenerate

  // Read FSM state; rd_state is the observable state of the handshake.
  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_ACK  = 1'b1
  } rd_state_t;

  rd_state_t rd_state;
  logic      rearm;
  logic      capture;

  // A capture happens on an edge where the FSM is idle, the request is high,
  // and the request has been seen low since the last capture.
  assign capture = (rd_state == RD_IDLE) && rd_req && rearm;

  // Per-channel next state. A write via en always overrides clear-on-read,
  // so a set landing on the capture edge survives for the next read.
  logic [CHANNELS-1:0] q_next;

  always_comb begin
    q_next = q;
    for (int i = 0; i < CHANNELS; i++) begin
      if (clr && ((SET_PRIORITY == 0) || !(en_y[i] && s_y[i]))) begin
        q_next[i] = 1'b0;
      end else if (en_y[i]) begin
        q_next[i] = s_y[i];
      end else if (capture && (CLEAR_ON_READ != 0) && q[i]) begin
        q_next[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= q_next;
    end
  end

  assign any = |q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state <= RD_IDLE;
      rd_ack   <= 1'b0;
      rd_data  <= '0;
      rearm    <= 1'b0;
    end else begin
      // rearm is cleared by a capture and set by any edge with rd_req low.
      if (capture) begin
        rearm <= 1'b0;
      end else if (!rd_req) begin
        rearm <= 1'b1;
      end

      case (rd_state)
        RD_IDLE: begin
          if (capture) begin
            rd_data  <= q;
            rd_ack   <= 1'b1;
            rd_state <= RD_ACK;
          end
        end
        RD_ACK: begin
          if (!rd_req) begin
            rd_ack   <= 1'b0;
            rd_state <= RD_IDLE;
          end
        end
        default: begin
          rd_ack   <= 1'b0;
          rd_state <= RD_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_srlor_bank.sv
// -----------------------------------------------------------------------------
// tb_srlor_bank
//
// Bench for srlor_bank. Two instances share all stimulus: dut uses the default
// clear-beats-set priority, dut_sp lets a same-cycle set beat clr. A
// behavioural model (input history queue plus mask arithmetic per edge) tracks
// the expected flags, snapshot and acknowledge for both. Inputs are driven on
// the falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_srlor_bank;

  localparam int CH = 8;
  localparam int SS = 2;

  logic          clk    = 1'b0;
  logic          rst_n  = 1'b0;
  logic [CH-1:0] en     = '0;
  logic [CH-1:0] s      = '0;
  logic          clr    = 1'b0;
  logic          rd_req = 1'b0;

  logic [CH-1:0] q, rd_data, q_sp, rd_data_sp;
  logic          any, rd_ack, any_sp, rd_ack_sp;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------------------------------------------------------- clock
  always #5 clk = ~clk;

  srlor_bank #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .CLEAR_ON_READ(1), .SET_PRIORITY(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .clr(clr),
    .q(q), .any(any), .rd_req(rd_req), .rd_ack(rd_ack), .rd_data(rd_data)
  );

  srlor_bank #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .CLEAR_ON_READ(1), .SET_PRIORITY(1)
  ) dut_sp (
    .clk(clk), .rst_n(rst_n), .en(en), .s(s), .clr(clr),
    .q(q_sp), .any(any_sp), .rd_req(rd_req), .rd_ack(rd_ack_sp),
    .rd_data(rd_data_sp)
  );

  // ------------------------------------------------------ reference model
  // Index 0 models set-loses-to-clr, index 1 models set-beats-clr.
  logic [CH-1:0] m_q    [2];
  logic [CH-1:0] m_data [2];
  logic          m_ack;
  logic          m_rearm;
  logic [CH-1:0] en_hist[$];
  logic [CH-1:0] s_hist[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q[0]    <= '0;
      m_q[1]    <= '0;
      m_data[0] <= '0;
      m_data[1] <= '0;
      m_ack     <= 1'b0;
      m_rearm   <= 1'b0;
      en_hist.delete();
      s_hist.delete();
      for (int k = 0; k < SS; k++) begin
        en_hist.push_back('0);
        s_hist.push_back('0);
      end
    end else begin
      automatic logic [CH-1:0] ey;
      automatic logic [CH-1:0] sy;
      automatic logic          cap;
      // An input sampled SS edges ago is what reaches the flags now.
      en_hist.push_back(en);
      s_hist.push_back(s);
      ey  = en_hist.pop_front();
      sy  = s_hist.pop_front();
      cap = !m_ack && rd_req && m_rearm;
      for (int p = 0; p < 2; p++) begin
        automatic logic [CH-1:0] rc;
        automatic logic [CH-1:0] nq;
        rc = cap ? m_q[p] : '0;
        nq = (m_q[p] & ~rc & ~ey) | (ey & sy);
        if (clr) nq = (p == 1) ? (ey & sy) : '0;
        if (cap) m_data[p] <= m_q[p];
        m_q[p] <= nq;
      end
      if (cap) begin
        m_ack   <= 1'b1;
        m_rearm <= 1'b0;
      end else begin
        if (m_ack && !rd_req) m_ack <= 1'b0;
        if (!rd_req) m_rearm <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------- driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // One-cycle en pulse; s is left at its value afterwards.
  task automatic pulse(input logic [CH-1:0] mask, input logic [CH-1:0] val);
    en = mask;
    s  = val;
    tick(1);
    en = '0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0;
    tick(2);
    vectors++;
    if (q !== 8'h00) begin
      miscompares++; $display("FAIL reset_q: got %h expected 00", q);
    end
    vectors++;
    if (any !== 1'b0) begin
      miscompares++; $display("FAIL reset_any: got %b expected 0", any);
    end
    vectors++;
    if (rd_ack !== 1'b0) begin
      miscompares++; $display("FAIL reset_ack: got %b expected 0", rd_ack);
    end
    vectors++;
    if (rd_data !== 8'h00) begin
      miscompares++; $display("FAIL reset_data: got %h expected 00", rd_data);
    end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_latency();
    pulse(8'h08, 8'h08);
    vectors++;
    if (q !== 8'h00) begin
      miscompares++; $display("FAIL lat_edge1: got %h expected 00", q);
    end
    tick(1);
    vectors++;
    if (q !== 8'h00) begin
      miscompares++; $display("FAIL lat_edge2: got %h expected 00", q);
    end
    tick(1);
    vectors++;
    if (q !== 8'h08 || any !== 1'b1) begin
      miscompares++;
      $display("FAIL lat_edge3: got q=%h any=%b expected q=08 any=1", q, any);
    end
    pulse(8'h08, 8'h00);
    tick(2);
    vectors++;
    if (q !== 8'h00 || any !== 1'b0) begin
      miscompares++;
      $display("FAIL lat_clear: got q=%h any=%b expected q=00 any=0", q, any);
    end
  endtask

  task automatic test_clear_on_read();
    pulse(8'h21, 8'h21);
    tick(2);
    vectors++;
    if (q !== 8'h21) begin
      miscompares++; $display("FAIL cor_setup: got %h expected 21", q);
    end
    rd_req = 1'b1;
    tick(1);
    vectors++;
    if (rd_ack !== 1'b1 || rd_data !== 8'h21 || q !== 8'h00) begin
      miscompares++;
      $display("FAIL cor_capture: got ack=%b data=%h q=%h expected 1 21 00",
               rd_ack, rd_data, q);
    end
    rd_req = 1'b0;
    tick(1);
    vectors++;
    if (rd_ack !== 1'b0 || rd_data !== 8'h21) begin
      miscompares++;
      $display("FAIL cor_release: got ack=%b data=%h expected 0 21",
               rd_ack, rd_data);
    end
  endtask

  task automatic test_collision();
    pulse(8'h01, 8'h01);
    tick(2);
    vectors++;
    if (q !== 8'h01) begin
      miscompares++; $display("FAIL col_setup: got %h expected 01", q);
    end
    // Second write reaches the flags on the third edge, the capture edge.
    pulse(8'h01, 8'h01);
    tick(1);
    rd_req = 1'b1;
    tick(1);
    vectors++;
    if (rd_ack !== 1'b1 || rd_data !== 8'h01 || q !== 8'h01) begin
      miscompares++;
      $display("FAIL col_capture: got ack=%b data=%h q=%h expected 1 01 01",
               rd_ack, rd_data, q);
    end
    rd_req = 1'b0;
    tick(1);
    rd_req = 1'b1;
    tick(1);
    vectors++;
    if (rd_data !== 8'h01 || q !== 8'h00) begin
      miscompares++;
      $display("FAIL col_second: got data=%h q=%h expected 01 00", rd_data, q);
    end
    rd_req = 1'b0;
    tick(1);
  endtask

  task automatic test_clr_priority();
    pulse(8'hFF, 8'hFF);
    tick(2);
    vectors++;
    if (q !== 8'hFF || q_sp !== 8'hFF) begin
      miscompares++;
      $display("FAIL pri_setup: got q=%h q_sp=%h expected FF FF", q, q_sp);
    end
    pulse(8'h04, 8'h04);
    tick(1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    vectors++;
    if (q !== 8'h00) begin
      miscompares++; $display("FAIL pri_clr_wins: got %h expected 00", q);
    end
    vectors++;
    if (q_sp !== 8'h04) begin
      miscompares++; $display("FAIL pri_set_wins: got %h expected 04", q_sp);
    end
  endtask

  task automatic test_rearm();
    int drops;
    drops  = 0;
    rd_req = 1'b1;
    tick(1);
    vectors++;
    if (rd_ack !== 1'b1 || rd_data_sp !== 8'h04 || q_sp !== 8'h00) begin
      miscompares++;
      $display("FAIL rearm_first: got ack=%b data_sp=%h q_sp=%h expected 1 04 00",
               rd_ack, rd_data_sp, q_sp);
    end
    // A flag set while rd_req stays high must not be consumed by a re-read.
    pulse(8'h10, 8'h10);
    for (int c = 0; c < 8; c++) begin
      if (rd_ack !== 1'b1) drops++;
      tick(1);
    end
    vectors++;
    if (drops !== 0 || rd_ack !== 1'b1) begin
      miscompares++;
      $display("FAIL rearm_hold_ack: got %0d low cycles expected 0", drops);
    end
    vectors++;
    if (q !== 8'h10 || rd_data !== 8'h00) begin
      miscompares++;
      $display("FAIL rearm_single: got q=%h data=%h expected 10 00", q, rd_data);
    end
    rd_req = 1'b0;
    tick(1);
    vectors++;
    if (rd_ack !== 1'b0) begin
      miscompares++; $display("FAIL rearm_drop: got %b expected 0", rd_ack);
    end
    rd_req = 1'b1;
    tick(1);
    vectors++;
    if (rd_ack !== 1'b1 || rd_data !== 8'h10 || q !== 8'h00) begin
      miscompares++;
      $display("FAIL rearm_second: got ack=%b data=%h q=%h expected 1 10 00",
               rd_ack, rd_data, q);
    end
    rd_req = 1'b0;
    tick(1);
  endtask

  task automatic test_async_reset();
    pulse(8'h55, 8'h55);
    tick(2);
    rd_req = 1'b1;
    tick(1);
    pulse(8'hAA, 8'hAA);
    tick(2);
    vectors++;
    if (q !== 8'hAA || rd_ack !== 1'b1 || rd_data !== 8'h55) begin
      miscompares++;
      $display("FAIL arst_setup: got q=%h ack=%b data=%h expected AA 1 55",
               q, rd_ack, rd_data);
    end
    // Assert reset between edges; outputs must clear without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (q !== 8'h00 || rd_ack !== 1'b0 || rd_data !== 8'h00) begin
      miscompares++;
      $display("FAIL arst_immediate: got q=%h ack=%b data=%h expected 00 0 00",
               q, rd_ack, rd_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
    vectors++;
    if (rd_ack !== 1'b0) begin
      miscompares++; $display("FAIL arst_no_retrigger: got %b expected 0", rd_ack);
    end
    rd_req = 1'b0;
    tick(1);
    rd_req = 1'b1;
    tick(1);
    vectors++;
    if (rd_ack !== 1'b1 || rd_data !== 8'h00) begin
      miscompares++;
      $display("FAIL arst_new_read: got ack=%b data=%h expected 1 00",
               rd_ack, rd_data);
    end
    rd_req = 1'b0;
    tick(1);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      en  = CH'($urandom & $urandom);
      s   = CH'($urandom);
      clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) rd_req = ~rd_req;
      tick(1);
      vectors++;
      if (q !== m_q[0] || any !== (|m_q[0])) begin
        miscompares++;
        $display("FAIL rand_q c=%0d: got q=%h any=%b expected q=%h any=%b",
                 c, q, any, m_q[0], |m_q[0]);
      end
      vectors++;
      if (rd_ack !== m_ack || rd_data !== m_data[0]) begin
        miscompares++;
        $display("FAIL rand_rd c=%0d: got ack=%b data=%h expected ack=%b data=%h",
                 c, rd_ack, rd_data, m_ack, m_data[0]);
      end
      vectors++;
      if (q_sp !== m_q[1] || rd_data_sp !== m_data[1] || any_sp !== (|m_q[1])) begin
        miscompares++;
        $display("FAIL rand_sp c=%0d: got q=%h data=%h expected q=%h data=%h",
                 c, q_sp, rd_data_sp, m_q[1], m_data[1]);
      end
      vectors++;
      if (rd_ack_sp !== m_ack) begin
        miscompares++;
        $display("FAIL rand_sp_ack c=%0d: got %b expected %b", c, rd_ack_sp, m_ack);
      end
    end
    en     = '0;
    clr    = 1'b0;
    rd_req = 1'b0;
    tick(2);
  endtask

  // ------------------------------------------------------------ sequence
  initial begin
    test_reset();
    test_latency();
    test_clear_on_read();
    test_collision();
    test_clr_priority();
    test_rearm();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/srlor_bank.md
Name: srlor_bank

Overview:
- Parametrised, clocked successor to the gate-level enable/set-reset latch.
- Holds CHANNELS independent flags. Each flag is written to the value of its s input whenever its en input is asserted.
- Provides a global synchronous clear, an OR-reduced "any" flag, and a 4-phase read handshake with optional clear-on-read.
- Sits between asynchronous handshake-circuit event sources and clocked control or status logic, so the en and s inputs are synchronised internally.

Parameters:
- CHANNELS, 8: number of flag channels (1..32).
- SYNC_STAGES, 2: synchroniser flops on each en and s bit (0 = bypass; otherwise 2..3).
- CLEAR_ON_READ, 1: 1 = flags captured by a read are cleared on the capture edge.
- SET_PRIORITY, 0: 0 = clr beats a same-cycle set; 1 = a same-cycle set beats clr.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  CHANNELS  per-channel enable; asynchronous to clk.
- s  in  CHANNELS  per-channel data; 1 = set, 0 = clear when en is asserted; asynchronous to clk.
- clr  in  1  synchronous global clear, active high.
- q  out  CHANNELS  flag state, registered.
- any  out  1  OR of q.
- rd_req  in  1  read request, 4-phase.
- rd_ack  out  1  read acknowledge, registered.
- rd_data  out  CHANNELS  snapshot of q, valid while rd_ack=1.

Behaviour:
- Reset (rst_n=0, asynchronous): q=0, any=0, rd_ack=0, rd_data=0, all synchroniser flops=0, FSM=IDLE. Release is synchronous to clk.
- Synchronisers: en and s each pass through SYNC_STAGES flops, giving en_y and s_y.
  - SYNC_STAGES=0: en_y=en, s_y=s.
  - Input-to-q latency is SYNC_STAGES+1 rising edges.
  - The bench holds s stable for at least one cycle around each en pulse.
- Per-channel next state, in priority order:
  - 1. clr=1 and (SET_PRIORITY=0 or not (en_y[i] and s_y[i])): q[i] becomes 0.
  - 2. en_y[i]=1: q[i] becomes s_y[i]. This is the set/clear write; set always wins over clear-on-read.
  - 3. Read capture this edge, CLEAR_ON_READ=1 and q[i]=1: q[i] becomes 0.
  - 4. Otherwise q[i] holds.
- any is the combinational OR of the q registers. It does not change between edges except on reset.
- Read FSM, 2 states:
  - IDLE: rd_ack=0. If rd_req=1 at an edge, capture: rd_data takes the pre-edge q, rd_ack becomes 1, go to ACK.
  - ACK: rd_data is frozen. If rd_req=0 at an edge, rd_ack becomes 0 and go to IDLE. rd_data keeps its last value.
  - rd_req held high after rd_ack falls does not retrigger a read: a capture needs rd_req observed low in IDLE first. Track this with a one-bit rearm flag, cleared on capture and set when rd_req=0.
- Lost-event rule: a set written on the capture edge is not in rd_data, and q stays 1 for the next read. No set is ever lost.
- clr does not affect the FSM or rd_data.
- Reset mid-handshake forces IDLE and rd_ack=0. The next read needs rd_req low then high.

Test Plan:
- Reset and latency: SYNC_STAGES=2; pulse en[3]=1, s[3]=1 for 1 cycle -> q=0x08 and any=1 exactly 3 edges later. Then en[3]=1, s[3]=0 -> q=0x00, any=0.
- Clear-on-read: set channels 0 and 5 (q=0x21); rd_req=1 -> rd_ack=1 next edge, rd_data=0x21, q=0x00. rd_req=0 -> rd_ack=0, rd_data still 0x21.
- Set vs read-clear collision: q=0x01; the synchronised en[0]=1, s[0]=1 lands on the capture edge -> rd_data=0x01, q stays 0x01. Second read returns 0x01, then q=0x00.
- clr priority: q=0xFF; clr=1 on the same edge as a synchronised set on ch2 -> q=0x00 with SET_PRIORITY=0, q=0x04 with SET_PRIORITY=1.
- Handshake rearm: hold rd_req=1 for 10 cycles -> exactly one capture, rd_ack stays 1. Drop rd_req then raise it -> second capture.
- Async reset mid-operation: assert rst_n=0 in ACK with q=0xAA -> q, rd_ack and rd_data go to 0 immediately, without waiting for a clock edge. After release, a new rd_req cycle returns 0x00.
